// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with a registered output stage.
// Ports: iCLK/iRST/iEN in; oVGA_X/Y coords out; iVGA_RGB in; oVGA_RGB/HS/VS/DE/FRAME_START out.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  output logic [10:0] oVGA_X,
  output logic [9:0]  oVGA_Y,
  input  logic        iVGA_R,
  input  logic        iVGA_G,
  input  logic        iVGA_B,
  output logic        oVGA_R,
  output logic        oVGA_G,
  output logic        oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_DE,
  output logic        oFRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] LP_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] LP_HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] LP_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  LP_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  LP_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  LP_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  LP_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_r, r_g, r_b;
  logic        r_hs, r_vs, r_de;
  logic        r_fs;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_origin;

  assign w_h_wrap = (r_hcnt == LP_H_LAST);
  assign w_v_wrap = (r_vcnt == LP_V_LAST);
  assign w_active = (r_hcnt < LP_H_ACT) && (r_vcnt < LP_V_ACT);
  assign w_hs_raw = (r_hcnt >= LP_HS_BEG) && (r_hcnt < LP_HS_END);
  // vcnt only moves on the hcnt wrap, so VS edges land on line starts.
  assign w_vs_raw = (r_vcnt >= LP_VS_BEG) && (r_vcnt < LP_VS_END);
  assign w_origin = (r_hcnt == 11'd0) && (r_vcnt == 10'd0);

  assign oVGA_X = w_active ? r_hcnt : 11'd0;
  assign oVGA_Y = w_active ? r_vcnt : 10'd0;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 10'd0;
    end else if (iEN) begin
      if (w_h_wrap) begin
        r_hcnt <= 11'd0;
        r_vcnt <= w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 11'd1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_de <= 1'b0;
      r_r  <= 1'b0;
      r_g  <= 1'b0;
      r_b  <= 1'b0;
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
    end else if (iEN) begin
      r_de <= w_active;
      r_r  <= w_active & iVGA_R;
      r_g  <= w_active & iVGA_G;
      r_b  <= w_active & iVGA_B;
      r_hs <= w_hs_raw ? SYNC_POL : ~SYNC_POL;
      r_vs <= w_vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Pulse clears on any edge so it stays one iCLK wide even at low iEN duty.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_fs <= 1'b0;
    else      r_fs <= iEN & w_origin;
  end

  assign oVGA_R       = r_r;
  assign oVGA_G       = r_g;
  assign oVGA_B       = r_b;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_DE      = r_de;
  assign oFRAME_START = r_fs;

endmodule
